// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the ROM address and fills the IF/ID register for decode.
// 1-clock fetch-to-IF/ID latency; stall holds PC and IF/ID, redirect overrides stall and flushes.
module fetch_unit #(
    parameter int                      PC_WIDTH    = 8,
    parameter int                      INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  HALT_OPCODE = '1,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [PC_WIDTH-1:0]     redirect_target,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0]  imem_instr,
    output logic                    if_valid,
    output logic [INSTR_WIDTH-1:0]  if_instr,
    output logic [PC_WIDTH-1:0]     if_pc,
    output logic [PC_WIDTH-1:0]     if_pc_plus1,
    output logic                    halted,
    output logic [15:0]             fetch_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_nxt;
    logic                  capture;
    logic                  flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        flush     = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
                if (redirect_valid) begin
                    pc_nxt = redirect_target;
                    flush  = 1'b1;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_target;
                    flush  = 1'b1;
                end else if (!stall) begin
                    capture = 1'b1;
                    // HALT word is delivered to decode but the PC parks on it.
                    if (imem_instr == HALT_OPCODE) begin
                        state_nxt = HALTED;
                    end else begin
                        pc_nxt = pc + PC_WIDTH'(1);
                    end
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_target;
                    flush     = 1'b1;
                    state_nxt = RUN;
                end else if (!stall) begin
                    flush = 1'b1;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
            fetch_count <= '0;
        end else begin
            pc <= pc_nxt;
            if (flush) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end else if (capture) begin
                if_valid    <= 1'b1;
                if_instr    <= imem_instr;
                if_pc       <= pc;
                if_pc_plus1 <= pc + PC_WIDTH'(1);
                if (fetch_count != 16'hFFFF) begin
                    fetch_count <= fetch_count + 16'd1;
                end
            end
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected IF/ID captures plus immediate assertions.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic [7:0]  if_pc_plus1;
    logic        halted;
    logic [15:0] fetch_count;

    // second instance with a non-zero reset PC to exercise the PC wrap
    logic        rst2_n;
    logic        idle2 = 1'b0;
    logic [7:0]  tgt2 = 8'h00;
    logic [7:0]  imem_addr2;
    logic [15:0] imem_instr2;
    logic        if_valid2;
    logic [15:0] if_instr2;
    logic [7:0]  if_pc2;
    logic [7:0]  if_pc_plus1_2;
    logic        halted2;
    logic [15:0] fetch_count2;

    logic [15:0] rom  [256];
    logic [15:0] rom2 [256];

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_instr  = rom[imem_addr];
    assign imem_instr2 = rom2[imem_addr2];

    fetch_unit u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus1     (if_pc_plus1),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    fetch_unit #(.RESET_PC(8'hFE)) u_dut_fe (
        .clk             (clk),
        .rst_n           (rst2_n),
        .stall           (idle2),
        .redirect_valid  (idle2),
        .redirect_target (tgt2),
        .imem_addr       (imem_addr2),
        .imem_instr      (imem_instr2),
        .if_valid        (if_valid2),
        .if_instr        (if_instr2),
        .if_pc           (if_pc2),
        .if_pc_plus1     (if_pc_plus1_2),
        .halted          (halted2),
        .fetch_count     (fetch_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] instr, input logic [7:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag, input logic v, input logic [15:0] ins,
                            input logic [7:0] p, input logic [7:0] p1);
        exp_t       e;
        logic [7:0] e1;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed capture with empty scoreboard, expected an entry", tag);
        end else begin
            e  = sb.pop_front();
            e1 = e.pc + 8'd1;
            chk({tag, ".valid"}, 32'(v), 32'd1);
            chk({tag, ".instr"}, 32'(ins), 32'(e.instr));
            chk({tag, ".pc"}, 32'(p), 32'(e.pc));
            chk({tag, ".pc_plus1"}, 32'(p1), 32'(e1));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 32'(if_valid), 32'd0);
        chk({tag, ".instr"}, 32'(if_instr), 32'h0000);
        chk({tag, ".pc"}, 32'(if_pc), 32'h00);
        chk({tag, ".pc_plus1"}, 32'(if_pc_plus1), 32'h00);
        chk({tag, ".halted"}, 32'(halted), 32'd0);
        chk({tag, ".count"}, 32'(fetch_count), 32'd0);
        chk({tag, ".addr"}, 32'(imem_addr), 32'h00);
    endtask

    task automatic fetch1(input string tag, input logic [7:0] pc);
        push(rom[pc], pc);
        tick();
        sb_check(tag, if_valid, if_instr, if_pc, if_pc_plus1);
    endtask

    task automatic fetch2(input string tag, input logic [7:0] pc);
        push(rom2[pc], pc);
        tick();
        sb_check(tag, if_valid2, if_instr2, if_pc2, if_pc_plus1_2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 16'h1000 + 16'(i);
            rom2[i] = 16'h2000 + 16'(i);
        end
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        rom[4] = 16'h5555;
        rom2[8'hFE] = 16'hAAAA; rom2[8'hFF] = 16'hBBBB; rom2[8'h00] = 16'hCCCC;

        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        chk("reset2.addr", 32'(imem_addr2), 32'hFE);
        rst_n = 1'b1;

        // BOOT cycle, then sequential fetch
        tick();
        chk("boot.valid", 32'(if_valid), 32'd0);
        chk("boot.addr", 32'(imem_addr), 32'h00);
        fetch1("f0", 8'h00);
        fetch1("f1", 8'h01);

        // stall while 2222 is in IF/ID
        stall = 1'b1;
        tick();
        tick();
        chk("stall.instr", 32'(if_instr), 32'h2222);
        chk("stall.pc", 32'(if_pc), 32'h01);
        chk("stall.addr", 32'(imem_addr), 32'h02);
        chk("stall.count", 32'(fetch_count), 32'd2);
        stall = 1'b0;
        fetch1("f2", 8'h02);
        chk("f2.count", 32'(fetch_count), 32'd3);
        fetch1("f3", 8'h03);
        fetch1("f4", 8'h04);

        // redirect wins over a simultaneous stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h40;
        tick();
        chk("redir.valid", 32'(if_valid), 32'd0);
        chk("redir.instr", 32'(if_instr), 32'h0000);
        chk("redir.addr", 32'(imem_addr), 32'h40);
        chk("redir.count", 32'(fetch_count), 32'd5);
        stall = 1'b0; redirect_valid = 1'b0;
        fetch1("f40", 8'h40);

        // move to PC=7, then async reset between edges
        redirect_valid = 1'b1; redirect_target = 8'h06;
        tick();
        redirect_valid = 1'b0;
        fetch1("f6", 8'h06);
        chk("pre_rst.addr", 32'(imem_addr), 32'h07);
        #3 rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        rom[3] = 16'hFFFF;
        tick();
        chk("boot2.valid", 32'(if_valid), 32'd0);
        chk("boot2.addr", 32'(imem_addr), 32'h00);
        fetch1("r0", 8'h00);
        fetch1("r1", 8'h01);
        fetch1("r2", 8'h02);

        // HALT is captured as valid, then the PC parks
        fetch1("halt", 8'h03);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.addr", 32'(imem_addr), 32'h03);
        chk("halt.count", 32'(fetch_count), 32'd4);
        tick();
        chk("halted.valid", 32'(if_valid), 32'd0);
        chk("halted.instr", 32'(if_instr), 32'h0000);
        chk("halted.addr", 32'(imem_addr), 32'h03);
        tick();
        chk("halted2.count", 32'(fetch_count), 32'd4);
        chk("halted2.halted", 32'(halted), 32'd1);

        redirect_valid = 1'b1; redirect_target = 8'h10;
        tick();
        redirect_valid = 1'b0;
        chk("resume.halted", 32'(halted), 32'd0);
        chk("resume.addr", 32'(imem_addr), 32'h10);
        fetch1("f10", 8'h10);

        // redirect to the current PC still flushes and refetches
        redirect_valid = 1'b1; redirect_target = 8'h11;
        tick();
        redirect_valid = 1'b0;
        chk("self_redir.valid", 32'(if_valid), 32'd0);
        chk("self_redir.addr", 32'(imem_addr), 32'h11);
        fetch1("f11", 8'h11);
        chk("f11.count", 32'(fetch_count), 32'd6);

        // PC wrap on the RESET_PC=FE instance
        rst2_n = 1'b1;
        tick();
        chk("wrap.boot_valid", 32'(if_valid2), 32'd0);
        chk("wrap.boot_addr", 32'(imem_addr2), 32'hFE);
        fetch2("wrap_fe", 8'hFE);
        fetch2("wrap_ff", 8'hFF);
        fetch2("wrap_00", 8'h00);
        chk("wrap.count", 32'(fetch_count2), 32'd3);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 8-register, 16-bit processor. It owns the program counter and drives the address of the combinational-read instruction ROM (256 x 16). It captures the returned word into the IF/ID pipeline register for the decode stage. It handles stall, branch/jump redirect with flush, HALT detection and a retired-fetch counter.

Parameters:
PC_WIDTH, 8, program counter and ROM address width (256 words)
INSTR_WIDTH, 16, instruction word width
RESET_PC, 8'h00, PC value loaded on reset
HALT_OPCODE, 16'hFFFF, instruction encoding that halts fetch
NOP_INSTR, 16'h0000, value placed in if_instr on bubble/flush

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  decode/hazard stall; hold PC and IF/ID
redirect_valid  in  1  taken branch/jump from execute
redirect_target  in  PC_WIDTH  new PC on redirect
imem_addr  out  PC_WIDTH  address to instruction ROM, equals PC register
imem_instr  in  INSTR_WIDTH  combinational ROM data for imem_addr
if_valid  out  1  IF/ID register holds a real instruction
if_instr  out  INSTR_WIDTH  IF/ID instruction
if_pc  out  PC_WIDTH  address of if_instr
if_pc_plus1  out  PC_WIDTH  if_pc+1 mod 2^PC_WIDTH (link/branch base)
halted  out  1  fetch FSM in HALTED
fetch_count  out  16  number of valid instructions captured, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n low, async): PC=RESET_PC, FSM=BOOT, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus1=0, halted=0, fetch_count=0.
- imem_addr = PC register (no combinational path from inputs). ROM data is sampled in the same cycle, so fetch-to-IF/ID latency is 1 clock.
- FSM states:
  - BOOT: one cycle after reset deassert; if_valid=0; no PC change; next RUN. A redirect in BOOT loads the PC and goes to RUN.
  - RUN: normal fetch.
  - HALTED: PC frozen, no new capture.
- Per-cycle priority in RUN: redirect > stall > HALT detect > normal.
  - redirect_valid=1: PC<=redirect_target; if_valid<=0, if_instr<=NOP_INSTR (flush the wrong-path word); no count; stall ignored this cycle.
  - stall=1 (no redirect): PC, IF/ID, fetch_count hold.
  - Normal: if_instr<=imem_instr, if_pc<=PC, if_pc_plus1<=PC+1, if_valid<=1, fetch_count++ (saturating), PC<=PC+1. The PC wraps 8'hFF->8'h00 without a flag.
  - imem_instr==HALT_OPCODE (no stall/redirect): captured as normal (valid, counted), PC does NOT increment, FSM->HALTED.
- HALTED:
  - First non-stalled cycle: if_valid<=0, if_instr<=NOP_INSTR. Stays 0 thereafter.
  - stall holds IF/ID, so the HALT word remains presented.
  - redirect_valid=1 (older branch resolving): PC<=redirect_target, flush IF/ID, FSM->RUN, halted<=0.
  - halted=1 whenever FSM==HALTED.
- Reset asserted mid-operation returns everything to reset values immediately; no partial state survives.
- redirect_target equal to current PC is legal: the flush still occurs, and the same address is refetched next cycle.

Test Plan:
1. Reset release, ROM[0..3]=1111,2222,3333,4444, no stall -> cycle after BOOT: if_instr=1111,if_pc=0,if_pc_plus1=1,if_valid=1. Then 2222 (pc 1), 3333 (pc 2); fetch_count=3.
2. stall=1 for 2 cycles while if_instr=2222 -> IF/ID, imem_addr=2, fetch_count unchanged. After release, 3333 captured with if_pc=2.
3. redirect_valid=1, target=8'h40, asserted together with stall=1 at PC=5 -> next: if_valid=0,if_instr=0000, imem_addr=40. Following cycle: if_pc=40, valid.
4. RESET_PC=8'hFE, ROM[FE]=AAAA,[FF]=BBBB,[00]=CCCC -> if_pc sequence FE,FF,00; if_pc_plus1 for FF = 00.
5. ROM[3]=FFFF -> HALT captured valid (if_pc=3), halted=1, imem_addr stays 3. Next cycle if_valid=0; fetch_count frozen at 4. Then redirect to 8'h10 -> halted=0, fetch resumes at 10.
6. rst_n pulsed low mid-run at PC=7 (asynchronously, between edges) -> outputs immediately at reset values, fetch_count=0. After release: BOOT, then fetch from RESET_PC.
